aes_round_ctrl: RTL

- Sequencer for the AES-128 encryption round datapath: per-byte AddRoundKey state registers, SubBytes/ShiftRows/MixColumns, and key expansion.
- Accepts a plaintext block on a valid/ready handshake and registers it onto text_in_r.
- Generates the ld_r and kld initial-load strobes, then steps round enables and the round index through NR rounds.
- Holds the result-valid flag until the consumer accepts it.

---
 rtl/aes_round_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_ctrl
// Brief    : AES-128 round sequencer. Handles the load handshake, issues the
//            ld_r/kld strobes, steps the round index and holds the ciphertext
//            flag. Optional block counter: AES_ROUND_CTRL_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
module aes_round_ctrl #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    output logic          ld_ready,
    input  logic [127:0]  text_in,
    output logic [127:0]  text_in_r,
    output logic          ld_r,
    output logic          kld,
    output logic          round_en,
    output logic [RW-1:0] rnd,
    output logic          final_round,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
`ifdef AES_ROUND_CTRL_PERF_CNT_EN
    ,
    input  logic          cnt_clr,
    output logic [31:0]   blk_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [RW-1:0] c_nr      = RW'(NR);
    localparam logic [RW-1:0] c_rnd_one = RW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [RW-1:0] r_rnd;
    logic [RW-1:0] w_rnd_nxt;
    logic [127:0]  r_text;
    logic          w_accept;

    assign w_accept = (r_state == S_IDLE) && ld;

    always_comb begin
        w_state_nxt = r_state;
        w_rnd_nxt   = r_rnd;
        case (r_state)
            S_IDLE: begin
                w_rnd_nxt = '0;
                if (ld) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_ROUND;
                w_rnd_nxt   = c_rnd_one;
            end
            S_ROUND: begin
                // >= keeps a corrupted index from ever running past NR
                if (r_rnd >= c_nr) begin
                    w_state_nxt = S_DONE;
                    w_rnd_nxt   = '0;
                end else begin
                    w_rnd_nxt = r_rnd + c_rnd_one;
                end
            end
            S_DONE: begin
                w_rnd_nxt = '0;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_rnd_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rnd   <= '0;
            r_text  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rnd   <= w_rnd_nxt;
            if (w_accept) begin
                r_text <= text_in;
            end
        end
    end

    // Every output decodes from registered state only.
    assign text_in_r   = r_text;
    assign ld_ready    = (r_state == S_IDLE);
    assign ld_r        = (r_state == S_LOAD);
    assign kld         = (r_state == S_LOAD);
    assign round_en    = (r_state == S_ROUND);
    assign final_round = (r_state == S_ROUND) && (r_rnd == c_nr);
    assign out_valid   = (r_state == S_DONE);
    assign busy        = (r_state == S_LOAD) || (r_state == S_ROUND);
    assign rnd         = r_rnd;

`ifdef AES_ROUND_CTRL_PERF_CNT_EN
    logic [31:0] r_blk_cnt;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_blk_cnt <= '0;
        end else if ((r_state == S_DONE) && out_ready) begin
            r_blk_cnt <= r_blk_cnt + 32'd1;
        end
    end

    assign blk_cnt = r_blk_cnt;
`endif

endmodule
`default_nettype wire
